// File: rtl/booth16_pkg.sv
// Shared types and helpers for the radix-16 Booth partial-product generator.
package booth16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRECOMP = 2'd1,
        ST_EMIT    = 2'd2,
        ST_DONE    = 2'd3
    } pp_state_e;

    // Signed Booth digit, range -8..+8
    typedef logic signed [4:0] booth_digit_t;

    localparam int unsigned DIGIT_BITS = 4;

    // Number of radix-16 digits for an operand of the given width
    function automatic int unsigned ndig(input int unsigned width);
        return width / DIGIT_BITS;
    endfunction

    // Recode window {y[3:0], y_m1} into -8*y3 + 4*y2 + 2*y1 + y0 + y_m1
    function automatic booth_digit_t booth16_digit(input logic [4:0] window);
        booth_digit_t hi;
        booth_digit_t lo;
        hi = booth_digit_t'($signed(window[4:1]));
        lo = booth_digit_t'({4'b0000, window[0]});
        return hi + lo;
    endfunction

endpackage

// File: rtl/booth16_pp_gen_if.sv
// Command and partial-product stream bundle between the Booth generator and its neighbours.
interface booth16_pp_gen_if
    import booth16_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned NDIG = ndig(WIDTH);
    localparam int unsigned PPW  = WIDTH + 4;
    localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic                    start;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic                    busy;
    logic                    acc_clr;
    logic                    pp_valid;
    logic                    pp_ready;
    logic signed [PPW-1:0]   pp_data;
    booth_digit_t            pp_digit;
    logic [IDXW-1:0]         pp_idx;
    logic                    pp_last;
    logic                    done;

    // Generator side
    modport master (
        input  start, x_in, y_in, pp_ready,
        output busy, acc_clr, pp_valid, pp_data, pp_digit, pp_idx, pp_last, done
    );

    // Requester / accumulator side
    modport slave (
        output start, x_in, y_in, pp_ready,
        input  busy, acc_clr, pp_valid, pp_data, pp_digit, pp_idx, pp_last, done
    );

endinterface

// File: rtl/booth16_mult_sel.sv
// Selects and signs the multiple d*X from X and the precomputed hard multiples.
module booth16_mult_sel
    import booth16_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned PPW   = WIDTH + 4,
    localparam int unsigned MW    = WIDTH + 3
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [MW-1:0]    m3,
    input  logic signed [MW-1:0]    m5,
    input  logic signed [MW-1:0]    m7,
    input  booth_digit_t            digit,
    output logic signed [PPW-1:0]   pp_c
);

    logic signed [PPW-1:0] x_ext;
    logic signed [PPW-1:0] m3_ext;
    logic signed [PPW-1:0] m5_ext;
    logic signed [PPW-1:0] m7_ext;
    logic signed [PPW-1:0] mag;
    logic                  neg;
    logic [3:0]            abs_d;

    assign x_ext  = {{(PPW-WIDTH){x[WIDTH-1]}}, x};
    assign m3_ext = {{(PPW-MW){m3[MW-1]}}, m3};
    assign m5_ext = {{(PPW-MW){m5[MW-1]}}, m5};
    assign m7_ext = {{(PPW-MW){m7[MW-1]}}, m7};

    // Magnitude select on |d|, then negate for negative digits
    always_comb begin
        mag   = '0;
        neg   = digit[4];
        abs_d = neg ? 4'(-digit) : 4'(digit);
        case (abs_d)
            4'd1:    mag = x_ext;
            4'd2:    mag = x_ext <<< 1;
            4'd3:    mag = m3_ext;
            4'd4:    mag = x_ext <<< 2;
            4'd5:    mag = m5_ext;
            4'd6:    mag = m3_ext <<< 1;
            4'd7:    mag = m7_ext;
            4'd8:    mag = x_ext <<< 3;
            default: mag = '0;
        endcase
        pp_c = neg ? -mag : mag;
    end

endmodule

// File: rtl/booth16_pp_gen.sv
// Sequential radix-16 Booth recoder emitting one signed partial product per handshake, LSD first.
module booth16_pp_gen
    import booth16_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    booth16_pp_gen_if.master  bus
);

    localparam int unsigned NDIG = ndig(WIDTH);
    localparam int unsigned PPW  = WIDTH + 4;
    localparam int unsigned MW   = WIDTH + 3;
    localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);
    localparam logic [IDXW-1:0] IDX_PENU = IDXW'(NDIG - 2);

    pp_state_e               state;
    logic signed [WIDTH-1:0] x_q;
    logic signed [WIDTH-1:0] y_q;
    logic                    y_m1_q;
    logic signed [MW-1:0]    m3_q;
    logic signed [MW-1:0]    m5_q;
    logic signed [MW-1:0]    m7_q;
    logic [IDXW-1:0]         idx_q;
    logic                    busy_q;
    logic                    acc_clr_q;
    logic                    pp_valid_q;
    logic                    pp_last_q;
    logic                    done_q;
    logic signed [PPW-1:0]   pp_data_q;
    booth_digit_t            pp_digit_q;

    logic signed [MW-1:0]    x_mw;
    logic signed [MW-1:0]    m3_c;
    logic signed [MW-1:0]    m5_c;
    logic signed [MW-1:0]    m7_c;
    logic signed [MW-1:0]    sel_m3;
    logic signed [MW-1:0]    sel_m5;
    logic signed [MW-1:0]    sel_m7;
    logic [4:0]              win_c;
    booth_digit_t            digit_nxt_c;
    logic signed [PPW-1:0]   pp_nxt_c;
    logic                    hs_c;

    // Hard multiples from the captured multiplicand
    assign x_mw = {{(MW-WIDTH){x_q[WIDTH-1]}}, x_q};
    assign m3_c = (x_mw <<< 1) + x_mw;
    assign m5_c = (x_mw <<< 2) + x_mw;
    assign m7_c = (x_mw <<< 3) - x_mw;

    // Outputs are loaded one cycle ahead: PRECOMP prepares digit 0, each handshake prepares the next
    assign win_c  = (state == ST_PRECOMP) ? {y_q[3:0], y_m1_q} : {y_q[7:4], y_q[3]};
    assign sel_m3 = (state == ST_PRECOMP) ? m3_c : m3_q;
    assign sel_m5 = (state == ST_PRECOMP) ? m5_c : m5_q;
    assign sel_m7 = (state == ST_PRECOMP) ? m7_c : m7_q;
    assign digit_nxt_c = booth16_digit(win_c);
    assign hs_c = pp_valid_q & bus.pp_ready;

    booth16_mult_sel #(
        .WIDTH (WIDTH)
    ) u_mult_sel (
        .x     (x_q),
        .m3    (sel_m3),
        .m5    (sel_m5),
        .m7    (sel_m7),
        .digit (digit_nxt_c),
        .pp_c  (pp_nxt_c)
    );

    // Control FSM, operand shift register and registered stream outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            y_m1_q     <= 1'b0;
            m3_q       <= '0;
            m5_q       <= '0;
            m7_q       <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            acc_clr_q  <= 1'b0;
            pp_valid_q <= 1'b0;
            pp_last_q  <= 1'b0;
            done_q     <= 1'b0;
            pp_data_q  <= '0;
            pp_digit_q <= '0;
        end else begin
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        x_q       <= bus.x_in;
                        y_q       <= bus.y_in;
                        y_m1_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        acc_clr_q <= 1'b1;
                        state     <= ST_PRECOMP;
                    end
                end
                ST_PRECOMP: begin
                    m3_q       <= m3_c;
                    m5_q       <= m5_c;
                    m7_q       <= m7_c;
                    idx_q      <= '0;
                    pp_valid_q <= 1'b1;
                    pp_last_q  <= 1'b0;
                    pp_data_q  <= pp_nxt_c;
                    pp_digit_q <= digit_nxt_c;
                    state      <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (hs_c) begin
                        y_q    <= y_q >>> 4;
                        y_m1_q <= y_q[3];
                        if (idx_q == IDX_LAST) begin
                            idx_q      <= '0;
                            pp_valid_q <= 1'b0;
                            pp_last_q  <= 1'b0;
                            pp_data_q  <= '0;
                            pp_digit_q <= '0;
                            done_q     <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            idx_q      <= IDXW'(idx_q + 1'b1);
                            pp_last_q  <= (idx_q == IDX_PENU);
                            pp_data_q  <= pp_nxt_c;
                            pp_digit_q <= digit_nxt_c;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.acc_clr  = acc_clr_q;
    assign bus.pp_valid = pp_valid_q;
    assign bus.pp_data  = pp_data_q;
    assign bus.pp_digit = pp_digit_q;
    assign bus.pp_idx   = idx_q;
    assign bus.pp_last  = pp_last_q;
    assign bus.done     = done_q;

endmodule
